// File: rtl/aes_kat_sequencer_if.sv
// rtl/aes_kat_sequencer_if.sv - start/done request interface between the KAT sequencer and the AES core
//
// Ports (signals):
//   core_start   1    one-cycle request pulse toward the core
//   core_decrypt 1    0 = encrypt, 1 = decrypt
//   core_keylen  2    0 = 128, 1 = 192, 2 = 256
//   core_key     256  key, MSB-aligned, unused low bits zero
//   core_data    128  input block
//   core_done    1    one-cycle completion pulse from the core
//   core_result  128  output block, valid with core_done
// Modports: master (sequencer side), slave (core side).
interface aes_kat_sequencer_if;
  logic         core_start;
  logic         core_decrypt;
  logic [1:0]   core_keylen;
  logic [255:0] core_key;
  logic [127:0] core_data;
  logic         core_done;
  logic [127:0] core_result;

  modport master (
    output core_start, core_decrypt, core_keylen, core_key, core_data,
    input  core_done, core_result
  );

  modport slave (
    input  core_start, core_decrypt, core_keylen, core_key, core_data,
    output core_done, core_result
  );
endinterface

// File: rtl/aes_kat_sequencer.sv
// rtl/aes_kat_sequencer.sv - FIPS-197 known-answer self-test sequencer for an AES core
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   start    in   one-cycle pulse that begins a run (ignored while busy)
//   core     if   aes_kat_sequencer_if.master toward the AES core
//   busy     out  run in progress
//   done     out  run complete (held until next start)
//   fail     out  any enabled test failed or timed out
//   e128..d256 out per-test pass flags
// Optional: define AES_KAT_LOOP_EN to rerun the self-test continuously after
// the first start; flags then update per test, done pulses once per run and
// fail is sticky until reset.
module aes_kat_sequencer #(
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [2:0] TEST_MASK      = 3'b111
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  aes_kat_sequencer_if.master        core,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic                       e128,
  output logic                       d128,
  output logic                       e192,
  output logic                       d192,
  output logic                       e256,
  output logic                       d256
);
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  localparam int         CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] FIRST = TEST_MASK[0] ? 2'd0 : (TEST_MASK[1] ? 2'd1 : 2'd2);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE_ENC, S_WAIT_ENC, S_ISSUE_DEC, S_WAIT_DEC, S_NEXT, S_FINISH
  } state_t;

  state_t             r_state, w_next_state;
  logic [1:0]         r_size;
  logic [CNT_W-1:0]   r_cnt;
  logic [5:0]         r_flags;
  logic               r_fail_acc;
  logic               r_done;
  logic               r_fail;
  logic               w_go, w_run_start, w_capture, w_miss, w_advance;
  logic               w_timeout, w_has_next, w_resp_ok, w_dec;
  logic [1:0]         w_next_size;
  logic [127:0]       w_ct;
  logic [255:0]       w_key;
  logic [2:0]         w_flag_idx;

`ifdef AES_KAT_LOOP_EN
  logic r_loop;
  assign w_go = start | r_loop;
`else
  assign w_go = start;
`endif

  assign w_dec       = (r_state == S_ISSUE_DEC) || (r_state == S_WAIT_DEC);
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_has_next  = (r_size == 2'd0) ? (TEST_MASK[1] | TEST_MASK[2]) :
                       (r_size == 2'd1) ? TEST_MASK[2] : 1'b0;
  assign w_next_size = ((r_size == 2'd0) && TEST_MASK[1]) ? 2'd1 : 2'd2;
  assign w_ct        = (r_size == 2'd0) ? CT128 : (r_size == 2'd1) ? CT192 : CT256;
  assign w_key       = (r_size == 2'd0) ? K128  : (r_size == 2'd1) ? K192  : K256;
  // Decrypt must return the plaintext; encrypt must return the golden ciphertext.
  assign w_resp_ok   = (core.core_result == (w_dec ? PT : w_ct));
  assign w_flag_idx  = {r_size, w_dec};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state      = r_state;
    w_run_start       = 1'b0;
    w_capture         = 1'b0;
    w_miss            = 1'b0;
    w_advance         = 1'b0;
    core.core_start   = 1'b0;
    core.core_decrypt = 1'b0;
    core.core_keylen  = 2'd0;
    core.core_key     = '0;
    core.core_data    = '0;
    busy              = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_go) begin
          w_run_start  = 1'b1;
          w_next_state = (TEST_MASK == 3'b000) ? S_FINISH : S_ISSUE_ENC;
        end
      end
      S_ISSUE_ENC, S_ISSUE_DEC: begin
        core.core_start = 1'b1;
        w_next_state    = (r_state == S_ISSUE_ENC) ? S_WAIT_ENC : S_WAIT_DEC;
      end
      S_WAIT_ENC, S_WAIT_DEC: begin
        // A done coinciding with the timeout cycle is still taken as a response.
        if (core.core_done) begin
          w_capture    = 1'b1;
          w_next_state = (r_state == S_WAIT_ENC) ? S_ISSUE_DEC : S_NEXT;
        end else if (w_timeout) begin
          w_miss       = 1'b1;
          w_next_state = (r_state == S_WAIT_ENC) ? S_ISSUE_DEC : S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_has_next) begin
          w_advance    = 1'b1;
          w_next_state = S_ISSUE_ENC;
        end else begin
          w_next_state = S_FINISH;
        end
      end
      S_FINISH: begin
        busy         = 1'b0;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    // Request fields stay valid from the issue cycle through the wait.
    if (r_state inside {S_ISSUE_ENC, S_WAIT_ENC, S_ISSUE_DEC, S_WAIT_DEC}) begin
      core.core_decrypt = w_dec;
      core.core_keylen  = r_size;
      core.core_key     = w_key;
      core.core_data    = w_dec ? w_ct : PT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_size     <= 2'd0;
      r_cnt      <= '0;
      r_flags    <= '0;
      r_fail_acc <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
`ifdef AES_KAT_LOOP_EN
      r_loop     <= 1'b0;
`endif
    end else begin
      if (w_run_start) begin
        r_size <= FIRST;
`ifdef AES_KAT_LOOP_EN
        r_loop <= 1'b1;
`else
        r_flags    <= '0;
        r_fail_acc <= 1'b0;
        r_done     <= 1'b0;
        r_fail     <= 1'b0;
`endif
      end
`ifdef AES_KAT_LOOP_EN
      if (r_state == S_FINISH) r_done <= 1'b0;
`endif
      if (core.core_start)                                       r_cnt <= '0;
      else if ((r_state == S_WAIT_ENC) || (r_state == S_WAIT_DEC)) r_cnt <= r_cnt + CNT_W'(1);
      if (w_capture) begin
        r_flags[w_flag_idx] <= w_resp_ok;
        if (!w_resp_ok) r_fail_acc <= 1'b1;
      end
      if (w_miss) begin
        r_flags[w_flag_idx] <= 1'b0;
        r_fail_acc          <= 1'b1;
      end
      if (w_advance) r_size <= w_next_size;
      if ((w_next_state == S_FINISH) && (r_state != S_FINISH)) begin
        r_done <= 1'b1;
`ifdef AES_KAT_LOOP_EN
        r_fail <= r_fail | r_fail_acc;
`else
        // An empty mask goes IDLE -> FINISH in the same cycle the accumulator clears.
        r_fail <= w_run_start ? 1'b0 : r_fail_acc;
`endif
      end
    end
  end

  assign done = r_done;
  assign fail = r_fail;
  assign {d256, e256, d192, e192, d128, e128} = r_flags;
endmodule

// File: tb/tb_aes_kat_sequencer.sv
// tb/tb_aes_kat_sequencer.sv - directed self-checking bench for aes_kat_sequencer
module tb_aes_kat_sequencer;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk;
  logic reset;
  logic [2:0] start_s;
  logic [2:0] spur;
  logic [2:0] clr;
  logic [1:0] mode [3];
  logic [15:0] cyc;

  wire        busy_w [3];
  wire        done_w [3];
  wire        fail_w [3];
  wire [5:0]  flg_w  [3];
  wire        cs_w   [3];
  wire        dec_w  [3];
  wire [1:0]  kl_w   [3];
  wire [255:0] key_w [3];
  wire [127:0] data_w [3];
  wire [7:0]  nst_w  [3];
  wire        kl1_w  [3];
  wire [1:0]  fkl_w  [3];
  wire [15:0] gap_w  [3];
  wire [7:0]  hold_w [3];

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) cyc <= 16'd0;
    else        cyc <= cyc + 16'd1;
  end

  function automatic logic [255:0] exp_key(input logic [1:0] kl);
    case (kl)
      2'd0:    exp_key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
      2'd1:    exp_key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
      default: exp_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    endcase
  endfunction

  function automatic logic [127:0] exp_ct(input logic [1:0] kl);
    exp_ct = (kl == 2'd0) ? CT128 : (kl == 2'd1) ? CT192 : CT256;
  endfunction

  // Reference core: answers correctly only when key and input block are the FIPS-197 ones.
  function automatic logic [127:0] ref_out(input logic dec, input logic [1:0] kl,
                                           input logic [255:0] key, input logic [127:0] data);
    logic [127:0] good;
    good = dec ? PT : exp_ct(kl);
    if ((key == exp_key(kl)) && (data == (dec ? exp_ct(kl) : PT))) ref_out = good;
    else                                                          ref_out = ~good;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    aes_kat_sequencer_if u_if ();
    logic         m_done;
    logic [127:0] m_res;
    logic [127:0] m_resp;
    logic         pend;
    logic [4:0]   cd;
    logic         cap_dec;
    logic [1:0]   cap_kl;
    logic [7:0]   n_st;
    logic         kl1;
    logic [1:0]   fkl;
    logic [15:0]  s1, s2;
    logic [7:0]   hold;

    aes_kat_sequencer #(
      .TIMEOUT_CYCLES(g == 1 ? 16 : 1024),
      .TEST_MASK     (g == 2 ? 3'b101 : 3'b111)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .start (start_s[g]),
      .core  (u_if.master),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .fail  (fail_w[g]),
      .e128  (flg_w[g][0]),
      .d128  (flg_w[g][1]),
      .e192  (flg_w[g][2]),
      .d192  (flg_w[g][3]),
      .e256  (flg_w[g][4]),
      .d256  (flg_w[g][5])
    );

    assign u_if.core_done   = m_done | spur[g];
    assign u_if.core_result = m_res;
    assign cs_w[g]   = u_if.core_start;
    assign dec_w[g]  = u_if.core_decrypt;
    assign kl_w[g]   = u_if.core_keylen;
    assign key_w[g]  = u_if.core_key;
    assign data_w[g] = u_if.core_data;
    assign nst_w[g]  = n_st;
    assign kl1_w[g]  = kl1;
    assign fkl_w[g]  = fkl;
    assign gap_w[g]  = s2 - s1;
    assign hold_w[g] = hold;

    always @(posedge clk) begin
      m_done <= 1'b0;
      if (!reset) begin
        pend <= 1'b0;
        m_res <= '0;
      end else if (u_if.core_start) begin
        pend    <= 1'b1;
        cd      <= 5'd11;
        cap_dec <= u_if.core_decrypt;
        cap_kl  <= u_if.core_keylen;
        m_resp  <= ref_out(u_if.core_decrypt, u_if.core_keylen, u_if.core_key, u_if.core_data)
                   ^ {127'b0, (mode[g] == 2'd1) && u_if.core_decrypt && (u_if.core_keylen == 2'd1)};
      end else if (pend) begin
        if (cd == 5'd0) begin
          pend <= 1'b0;
          if (mode[g] != 2'd2) begin
            m_done <= 1'b1;
            m_res  <= m_resp;
          end
        end else begin
          cd <= cd - 5'd1;
        end
      end
      if (clr[g]) begin
        n_st <= 8'd0;
        kl1  <= 1'b0;
        fkl  <= 2'd3;
        s1   <= 16'd0;
        s2   <= 16'd0;
        hold <= 8'd0;
      end else if (reset) begin
        if (u_if.core_start) begin
          n_st <= n_st + 8'd1;
          if (n_st == 8'd0) begin fkl <= u_if.core_keylen; s1 <= cyc; end
          if (n_st == 8'd1) s2 <= cyc;
          if (u_if.core_keylen == 2'd1) kl1 <= 1'b1;
        end else if (pend && ((u_if.core_decrypt != cap_dec) || (u_if.core_keylen != cap_kl))) begin
          hold <= hold + 8'd1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int i);
    @(negedge clk);
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  task automatic pulse_clr(input int i);
    @(negedge clk);
    clr[i] = 1'b1;
    @(negedge clk);
    clr[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    while (!done_w[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", 256'(done_w[i]), 256'd1);
  endtask

  function automatic logic [255:0] outs(input int i);
    outs = 256'({busy_w[i], done_w[i], fail_w[i], flg_w[i], cs_w[i], dec_w[i], kl_w[i],
                 |key_w[i], |data_w[i]});
  endfunction

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    reset   = 1'b0;
    start_s = 3'b000;
    spur    = 3'b000;
    clr     = 3'b111;
    for (int i = 0; i < 3; i++) mode[i] = 2'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(0), 256'd0);
    reset = 1'b1;
    clr   = 3'b000;
    @(negedge clk);

    // Spurious done while idle must not start anything.
    spur[0] = 1'b1;
    @(negedge clk);
    spur[0] = 1'b0;
    @(negedge clk);
    check("spurious_done_idle", 256'({busy_w[0], done_w[0], nst_w[0]}), 256'd0);

    // Nominal run with a stray start while busy.
    pulse_start(0);
    check("busy_after_start", 256'(busy_w[0]), 256'd1);
    repeat (20) @(negedge clk);
    pulse_start(0);
    wait_done(0, 2000);
    check("nominal_flags", 256'(flg_w[0]), 256'h3f);
    check("nominal_fail", 256'(fail_w[0]), 256'd0);
    check("nominal_busy_at_done", 256'(busy_w[0]), 256'd0);
    check("nominal_starts", 256'(nst_w[0]), 256'd6);
    check("nominal_hold", 256'(hold_w[0]), 256'd0);

    // Corrupted 192-bit decrypt result.
    mode[0] = 2'd1;
    pulse_clr(0);
    pulse_start(0);
    check("done_cleared_by_start", 256'(done_w[0]), 256'd0);
    wait_done(0, 2000);
    check("corrupt_flags", 256'(flg_w[0]), 256'h37);
    check("corrupt_fail", 256'(fail_w[0]), 256'd1);

    // Core that never answers, 16-cycle timeout.
    mode[1] = 2'd2;
    pulse_start(1);
    wait_done(1, 400);
    check("timeout_flags", 256'(flg_w[1]), 256'd0);
    check("timeout_fail", 256'(fail_w[1]), 256'd1);
    check("timeout_gap", 256'(gap_w[1]), 256'd17);
    check("timeout_starts", 256'(nst_w[1]), 256'd6);

    // Mask 3'b101 skips the 192-bit tests.
    pulse_start(2);
    wait_done(2, 2000);
    check("mask_flags", 256'(flg_w[2]), 256'h33);
    check("mask_fail", 256'(fail_w[2]), 256'd0);
    check("mask_starts", 256'(nst_w[2]), 256'd4);
    check("mask_no_192", 256'(kl1_w[2]), 256'd0);

    // Async reset in the middle of the 256-bit decrypt wait.
    mode[0] = 2'd0;
    pulse_clr(0);
    pulse_start(0);
    n = 0;
    while (!(dec_w[0] && kl_w[0] == 2'd2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_dec256", 256'(dec_w[0] && kl_w[0] == 2'd2), 256'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", outs(0), 256'd0);
    @(negedge clk);
    reset = 1'b1;
    pulse_clr(0);
    pulse_start(0);
    wait_done(0, 2000);
    check("rerun_first_keylen", 256'(fkl_w[0]), 256'd0);
    check("rerun_flags", 256'(flg_w[0]), 256'h3f);
    check("rerun_fail", 256'(fail_w[0]), 256'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
